// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - state and trigger-mode encodings shared by the capture sequencer and status logic
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOCKWAIT = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_IDLE     = 3'd2,
    ST_ARMED    = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_DRAIN    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM  = 2'b00,
    TRIG_RISE = 2'b01,
    TRIG_FALL = 2'b10,
    TRIG_EXT  = 2'b11
  } trig_mode_t;

  function automatic logic state_busy(input seq_state_t s);
    return (s == ST_ARMED) || (s == ST_CAPTURE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_capture_seq.sv
// rtl/adc_capture_seq.sv - lock-qualified arm/trigger/capture sequencer driving the sample FIFO write enable
module adc_capture_seq
  import adc_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12,
  parameter int SETTLE = 1024
) (
  input  logic              dclk,
  input  logic              mr,
  input  logic              locked,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic              trig_ext,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] sample,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              wen,
  output logic              busy,
  output logic              done,
  output logic              err_lock,
  output logic              err_ovf,
  output logic [2:0]        state
);

  localparam int SET_W = $clog2(SETTLE + 1);

  seq_state_t        st, st_nxt;
  trig_mode_t        mode_q;
  logic              lock_s;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W:0]    cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_vld;
  logic              trig_hit;
  logic              arm_take;

  sync_2ff u_lock_sync (
    .clk   (dclk),
    .rst_n (mr),
    .d     (locked),
    .q     (lock_s)
  );

  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      TRIG_IMM:  trig_hit = 1'b1;
      TRIG_RISE: trig_hit = prev_vld && (prev < trig_level) && (sample >= trig_level);
      TRIG_FALL: trig_hit = prev_vld && (prev > trig_level) && (sample <= trig_level);
      TRIG_EXT:  trig_hit = trig_ext;
      default:   trig_hit = 1'b0;
    endcase
  end

  always_ff @(posedge dclk or negedge mr) begin
    if (!mr) st <= ST_LOCKWAIT;
    else     st <= st_nxt;
  end

  // Lock loss outranks abort, which outranks trigger and count completion.
  always_comb begin
    st_nxt = st;
    if (!lock_s) begin
      st_nxt = ST_LOCKWAIT;
    end else begin
      case (st)
        ST_LOCKWAIT: st_nxt = ST_SETTLE;
        ST_SETTLE:   if (settle_cnt == SET_W'(SETTLE - 1)) st_nxt = ST_IDLE;
        ST_IDLE:     if (arm) st_nxt = ST_ARMED;
        ST_ARMED:    if (abort) st_nxt = ST_DRAIN;
                     else if (trig_hit) st_nxt = ST_CAPTURE;
        ST_CAPTURE:  if (abort || fifo_full || (cnt == (CNT_W+1)'(1))) st_nxt = ST_DRAIN;
        ST_DRAIN:    if (fifo_empty) st_nxt = ST_IDLE;
        default:     st_nxt = ST_LOCKWAIT;
      endcase
    end
  end

  // A full FIFO suppresses the write in the same cycle so nothing is lost silently.
  always_comb begin
    wen   = (st == ST_CAPTURE) && !fifo_full;
    busy  = state_busy(st);
    done  = (st == ST_DRAIN);
    state = st;
  end

  assign arm_take = (st == ST_IDLE) && (st_nxt == ST_ARMED);

  always_ff @(posedge dclk or negedge mr) begin
    if (!mr) begin
      settle_cnt <= '0;
      cnt        <= '0;
      mode_q     <= TRIG_IMM;
      prev       <= '0;
      prev_vld   <= 1'b0;
      err_lock   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      settle_cnt <= (st == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      prev       <= sample;
      prev_vld   <= !arm_take;
      if (arm_take) begin
        mode_q   <= trig_mode_t'(trig_mode);
        cnt      <= (num_samples == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, num_samples};
        err_lock <= 1'b0;
        err_ovf  <= 1'b0;
      end else begin
        if (wen) cnt <= cnt - 1'b1;
        if (!lock_s && ((st == ST_ARMED) || (st == ST_CAPTURE))) err_lock <= 1'b1;
        if ((st == ST_CAPTURE) && fifo_full) err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_seq.sv
// tb/tb_adc_capture_seq.sv - directed bench with a timeline model of the capture sequencer
module tb_adc_capture_seq;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int SETTLE = 16;
  localparam int NCYC   = 175;
  localparam int S_LW = 0, S_SET = 1, S_IDLE = 2, S_ARM = 3, S_CAP = 4, S_DRN = 5;

  logic              dclk, mr, locked, arm, abort, trig_ext, fifo_full, fifo_empty;
  logic [1:0]        trig_mode;
  logic [DATA_W-1:0] trig_level, sample;
  logic [CNT_W-1:0]  num_samples;
  logic              wen, busy, done, err_lock, err_ovf;
  logic [2:0]        state;

  adc_capture_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .dclk(dclk), .mr(mr), .locked(locked), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_ext(trig_ext), .trig_level(trig_level),
    .sample(sample), .num_samples(num_samples), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .wen(wen), .busy(busy), .done(done),
    .err_lock(err_lock), .err_ovf(err_ovf), .state(state)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic              in_locked[NCYC], in_arm[NCYC], in_abort[NCYC], in_ext[NCYC];
  logic              in_full[NCYC], in_empty[NCYC];
  logic [1:0]        in_mode[NCYC];
  logic [DATA_W-1:0] in_sample[NCYC];
  logic [CNT_W-1:0]  in_num[NCYC];
  int                exp_st[NCYC], obs_st[NCYC];
  logic              exp_wen[NCYC], exp_el[NCYC], exp_eo[NCYC];
  logic              obs_wen[NCYC], obs_el[NCYC], obs_eo[NCYC];

  int   n_cmp = 0, n_bad = 0;
  int   cur = 0, cyc = 0;
  bit   running = 1'b0;
  logic ex_el = 1'b0, ex_eo = 1'b0;

  task automatic chk(input string name, input int k, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, k, act, expv);
    end
  endtask

  // Expected timeline: cycles cur..k_end hold one state/wen with the current sticky flags.
  task automatic fill(input int k_end, input int stv, input logic w);
    for (int k = cur; k <= k_end; k++) begin
      exp_st[k]  = stv;
      exp_wen[k] = w;
      exp_el[k]  = ex_el;
      exp_eo[k]  = ex_eo;
    end
    cur = k_end + 1;
  endtask

  // Complete capture: arm at a, trigger condition true at tk, drained at ek.
  task automatic seq(input int a, input int mode, input int tk, input int n, input int ek);
    int neff;
    neff = (n == 0) ? (1 << CNT_W) : n;
    in_arm[a]   = 1'b1;
    in_mode[a]  = 2'(mode);
    in_num[a]   = CNT_W'(n);
    in_empty[ek] = 1'b1;
    fill(a, S_IDLE, 1'b0);
    ex_el = 1'b0;
    ex_eo = 1'b0;
    fill(tk, S_ARM, 1'b0);
    fill(tk + neff, S_CAP, 1'b1);
    fill(ek, S_DRN, 1'b0);
  endtask

  always @(negedge dclk) begin
    if (running) begin
      obs_st[cyc]  = int'(state);
      obs_wen[cyc] = wen;
      obs_el[cyc]  = err_lock;
      obs_eo[cyc]  = err_ovf;
      chk("state", cyc, int'(state), exp_st[cyc]);
      chk("wen", cyc, int'(wen), int'(exp_wen[cyc]));
      chk("busy", cyc, int'(busy), (exp_st[cyc] >= S_ARM && exp_st[cyc] <= S_DRN) ? 1 : 0);
      chk("done", cyc, int'(done), (exp_st[cyc] == S_DRN) ? 1 : 0);
      chk("err_lock", cyc, int'(err_lock), int'(exp_el[cyc]));
      chk("err_ovf", cyc, int'(err_ovf), int'(exp_eo[cyc]));
    end
  end

  initial begin
    int wsum, wtot;
    for (int k = 0; k < NCYC; k++) begin
      in_locked[k] = (k >= 2) && !(k >= 128 && k <= 134);
      in_arm[k] = 1'b0; in_abort[k] = 1'b0; in_ext[k] = 1'b0;
      in_full[k] = 1'b0; in_empty[k] = 1'b0; in_mode[k] = 2'b00;
      in_sample[k] = 8'h00; in_num[k] = '0;
    end

    // Lock qualification: locked rises at 2, SETTLE from 5 for 16 cycles.
    fill(4, S_LW, 1'b0);
    fill(20, S_SET, 1'b0);
    // Immediate, 5 samples; a stray arm in DRAIN is ignored.
    seq(25, 0, 26, 5, 34);
    in_arm[33] = 1'b1;
    // Rising threshold ramp.
    in_sample[41] = 8'h7E; in_sample[42] = 8'h7F; in_sample[43] = 8'h80; in_sample[44] = 8'h81;
    seq(40, 1, 43, 3, 49);
    // Constant 0x90 never crosses; prev from the arm cycle must not count; abort from ARMED.
    in_arm[55] = 1'b1; in_mode[55] = 2'b01; in_num[55] = 4'd3; in_sample[55] = 8'h7F;
    for (int k = 56; k <= 66; k++) in_sample[k] = 8'h90;
    in_abort[66] = 1'b1; in_empty[68] = 1'b1;
    fill(55, S_IDLE, 1'b0); ex_el = 1'b0; ex_eo = 1'b0;
    fill(66, S_ARM, 1'b0);
    fill(68, S_DRN, 1'b0);
    // Falling threshold.
    in_sample[73] = 8'h90; in_sample[74] = 8'h85; in_sample[75] = 8'h80;
    seq(72, 2, 75, 2, 79);
    // External trigger, num_samples 0 means 16.
    in_ext[87] = 1'b1;
    seq(84, 3, 87, 0, 106);
    // Overflow after 3 writes of 8.
    in_arm[110] = 1'b1; in_num[110] = 4'd8; in_full[115] = 1'b1; in_empty[118] = 1'b1;
    fill(110, S_IDLE, 1'b0); ex_el = 1'b0; ex_eo = 1'b0;
    fill(111, S_ARM, 1'b0);
    fill(114, S_CAP, 1'b1);
    fill(115, S_CAP, 1'b0);
    ex_eo = 1'b1;
    fill(118, S_DRN, 1'b0);
    // Lock lost mid-capture (locked low 128..134), then relock.
    in_arm[122] = 1'b1; in_num[122] = 4'd10;
    fill(122, S_IDLE, 1'b0); ex_el = 1'b0; ex_eo = 1'b0;
    fill(123, S_ARM, 1'b0);
    fill(130, S_CAP, 1'b1);
    ex_el = 1'b1;
    fill(137, S_LW, 1'b0);
    fill(153, S_SET, 1'b0);
    // Abort during CAPTURE; arm clears err_lock.
    in_arm[158] = 1'b1; in_num[158] = 4'd4; in_abort[161] = 1'b1; in_empty[164] = 1'b1;
    fill(158, S_IDLE, 1'b0); ex_el = 1'b0; ex_eo = 1'b0;
    fill(159, S_ARM, 1'b0);
    fill(161, S_CAP, 1'b1);
    fill(164, S_DRN, 1'b0);
    fill(NCYC - 1, S_IDLE, 1'b0);

    mr = 1'b0; locked = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 2'b00; trig_ext = 1'b0;
    trig_level = 8'h80; sample = 8'h00; num_samples = '0; fifo_full = 1'b0; fifo_empty = 1'b0;
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    chk("rst_wen", -1, int'(wen), 0);
    chk("rst_busy", -1, int'(busy), 0);
    chk("rst_done", -1, int'(done), 0);
    chk("rst_err_lock", -1, int'(err_lock), 0);
    chk("rst_err_ovf", -1, int'(err_ovf), 0);
    chk("rst_state", -1, int'(state), 0);
    mr = 1'b1;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge dclk);
      #2;
      cyc = k;
      running = 1'b1;
      locked = in_locked[k]; arm = in_arm[k]; abort = in_abort[k]; trig_mode = in_mode[k];
      trig_ext = in_ext[k]; sample = in_sample[k]; num_samples = in_num[k];
      fifo_full = in_full[k]; fifo_empty = in_empty[k];
    end
    @(negedge dclk);
    #1;
    running = 1'b0;

    chk("lit_lockwait_end", 4, obs_st[4], 0);
    chk("lit_settle_start", 5, obs_st[5], 1);
    chk("lit_settle_end", 20, obs_st[20], 1);
    chk("lit_idle", 21, obs_st[21], 2);
    chk("lit_armed", 26, obs_st[26], 3);
    chk("lit_first_wen", 27, int'(obs_wen[27]), 1);
    chk("lit_drain_after5", 32, obs_st[32], 5);
    chk("lit_rise_armed", 43, obs_st[43], 3);
    chk("lit_rise_capture", 44, obs_st[44], 4);
    chk("lit_abort_drain", 67, obs_st[67], 5);
    chk("lit_ovf_wen", 115, int'(obs_wen[115]), 0);
    chk("lit_ovf_flag", 116, int'(obs_eo[116]), 1);
    chk("lit_ovf_clear", 123, int'(obs_eo[123]), 0);
    chk("lit_lock_state", 131, obs_st[131], 0);
    chk("lit_lock_flag", 131, int'(obs_el[131]), 1);
    chk("lit_lock_clear", 159, int'(obs_el[159]), 0);
    wsum = 0;
    wtot = 0;
    for (int k = 0; k < NCYC; k++) begin
      if (k >= 84 && k <= 110 && obs_wen[k]) wsum++;
      if (obs_wen[k]) wtot++;
    end
    chk("lit_wen_count_len0", 84, wsum, 16);
    chk("lit_wen_count_total", NCYC, wtot, 38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
